cmp_config_loader: RTL and testbench

CMP_CONFIG_LOADER -- requirements
Module: cmp_config_loader

---
 rtl/cmp_config_loader_pkg.sv | 38 +++
 rtl/cmp_config_loader.sv | 172 +++++++++++++++++
 tb/tb_cmp_config_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_config_loader_pkg.sv
// Shared sizing defines (main.vh contents) and state encodings for cmp_config_loader.
// Optional feature macro: CMP_CONFIG_CHECKSUM_EN (adds the CSUM state and XOR check).
`ifndef CMP_MAIN_VH
`define CMP_MAIN_VH
`define NUM_HASHES 8
`define HASH_NUM_MSB 2
`define HASH_COUNT_MSB 3
`endif

package cmp_config_loader_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = `HASH_NUM_MSB + 3;
  localparam int unsigned HCNT_W = `HASH_COUNT_MSB + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef CMP_CONFIG_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd4;
`endif
  localparam logic [2:0] ST_MAGIC  = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    CNT_LO = ST_CNT_LO,
    CNT_HI = ST_CNT_HI,
    DATA   = ST_DATA,
`ifdef CMP_CONFIG_CHECKSUM_EN
    CSUM   = ST_CSUM,
`endif
    MAGIC  = ST_MAGIC,
    ERR    = ST_ERR
  } state_e;

endpackage

// File: rtl/cmp_config_loader.sv
// Loads a hash configuration packet from a byte FIFO into comparator memory.
// Define CMP_CONFIG_CHECKSUM_EN to require an XOR checksum byte before the magic terminator.
module cmp_config_loader
  import cmp_config_loader_pkg::*;
#(
  parameter logic [DATA_W-1:0] CONFIG_MAGIC = 8'hCC,
  parameter int unsigned       MAX_COUNT    = `NUM_HASHES
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              empty,
  output logic              rd_en,
  input  logic              start,
  output logic [DATA_W-1:0] dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [HCNT_W-1:0] hash_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   cnt_lo_q, cnt_lo_d;
  logic [HCNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, last_idx;
  logic [2*DATA_W-1:0] full_count;
  logic [DATA_W-1:0]   dout_d;
  logic                wr_en_d, done_d, error_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [HCNT_W-1:0]   hash_count_d;
  logic                take;
`ifdef CMP_CONFIG_CHECKSUM_EN
  logic [DATA_W-1:0]   xor_q, xor_d;
`endif

  // Busy covers every packet-consuming state; rd_en simply pops whenever a byte is there.
  assign busy  = (state_q != IDLE) && (state_q != ERR);
  assign rd_en = busy && !empty;
  assign take  = rd_en;

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    count_d      = count_q;
    idx_d        = idx_q;
    dout_d       = dout;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    hash_count_d = hash_count;
    done_d       = 1'b0;
    error_d      = error;
`ifdef CMP_CONFIG_CHECKSUM_EN
    xor_d        = xor_q;
`endif
    full_count   = {din, cnt_lo_q};
    last_idx     = ADDR_W'({count_q, 2'b00} - (HCNT_W+2)'(1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CNT_LO;
          error_d = 1'b0;
        end
      end
      CNT_LO: begin
        if (take) begin
          cnt_lo_d = din;
          state_d  = CNT_HI;
`ifdef CMP_CONFIG_CHECKSUM_EN
          xor_d    = din;
`endif
        end
      end
      CNT_HI: begin
        if (take) begin
`ifdef CMP_CONFIG_CHECKSUM_EN
          xor_d = xor_q ^ din;
`endif
          if ((full_count == '0) || (32'(full_count) > MAX_COUNT)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            count_d = HCNT_W'(full_count);
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (take) begin
          wr_en_d   = 1'b1;
          dout_d    = din;
          wr_addr_d = idx_q;
`ifdef CMP_CONFIG_CHECKSUM_EN
          xor_d     = xor_q ^ din;
`endif
          if (idx_q == last_idx) begin
`ifdef CMP_CONFIG_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = MAGIC;
`endif
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
`ifdef CMP_CONFIG_CHECKSUM_EN
      CSUM: begin
        if (take) begin
          if (din == xor_q) begin
            state_d = MAGIC;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      MAGIC: begin
        if (take) begin
          if (din == CONFIG_MAGIC) begin
            hash_count_d = count_q;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hash count resets to 1 so the comparator never sees a zero count.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      dout       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      hash_count <= HCNT_W'(1);
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef CMP_CONFIG_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      dout       <= dout_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      hash_count <= hash_count_d;
      done       <= done_d;
      error      <= error_d;
`ifdef CMP_CONFIG_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmp_config_loader.sv
// Scoreboard bench for cmp_config_loader: a byte-FIFO model feeds packets, writes are checked in order.
module tb_cmp_config_loader;
  import cmp_config_loader_pkg::*;

  logic              CLK = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic              empty;
  logic              rd_en;
  logic              start;
  logic [DATA_W-1:0] dout;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [HCNT_W-1:0] hash_count;
  logic              busy;
  logic              done;
  logic              error;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned done_cnt = 0;
  int unsigned wr_seen  = 0;
  logic [7:0]  fifo[$];
  logic [15:0] exp_q[$];
  bit          toggle_en = 1'b0;
  bit          stall = 1'b0;
  bit          take = 1'b0;
  logic [HCNT_W-1:0] exp_hc;

  cmp_config_loader dut (
    .CLK(CLK), .rst_n(rst_n), .din(din), .empty(empty), .rd_en(rd_en), .start(start),
    .dout(dout), .wr_en(wr_en), .wr_addr(wr_addr), .hash_count(hash_count),
    .busy(busy), .done(done), .error(error)
  );

  always #5 CLK = ~CLK;

  // Monitor writes against the scoreboard, then present the FIFO head for the next edge.
  always @(negedge CLK) begin
    logic [15:0] exp;
    if (rst_n && wr_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: got addr %0d data %02h, required no write", wr_addr, dout);
      end else begin
        exp = exp_q.pop_front();
        if ({8'(wr_addr), dout} !== exp) begin
          n_fails++;
          $display("FAIL write_seq: got addr %0d data %02h, required addr %0d data %02h",
                   wr_addr, dout, exp[15:8], exp[7:0]);
        end
      end
      wr_seen++;
    end
    if (rst_n && done) done_cnt++;
    stall = toggle_en ? ~stall : 1'b0;
    empty = stall || (fifo.size() == 0);
    din   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1 take = rd_en && !empty;
  end

  always @(posedge CLK) if (take && fifo.size() != 0) void'(fifo.pop_front());

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input int unsigned cnt, input int unsigned nb, input logic [7:0] step,
                          input logic [7:0] magic, input bit bad_csum, input bit with_tail);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'(cnt) ^ 8'(cnt >> 8);
    fifo.push_back(8'(cnt));
    fifo.push_back(8'(cnt >> 8));
    for (int i = 0; i < int'(nb); i++) begin
      b = 8'(step * 8'(i + 1));
      fifo.push_back(b);
      x ^= b;
      exp_q.push_back({8'(i), b});
    end
    if (with_tail) begin
`ifdef CMP_CONFIG_CHECKSUM_EN
      fifo.push_back(bad_csum ? 8'h00 : x);
`endif
      fifo.push_back(magic);
    end
  endtask

  task automatic run_pkt(output bit to);
    int n;
    done_cnt = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    to = (n >= 2000);
    @(negedge CLK);
  endtask

  task automatic check_end(input string name, input bit to, input bit exp_err, input int unsigned exp_done);
    n_checks++;
    if (to) begin n_fails++; $display("FAIL %s_timeout: busy still high, required completion", name); end
    n_checks++;
    if (error !== exp_err) begin n_fails++; $display("FAIL %s_error: got %0b, required %0b", name, error, exp_err); end
    n_checks++;
    if (done_cnt != exp_done) begin n_fails++; $display("FAIL %s_done: got %0d pulses, required %0d", name, done_cnt, exp_done); end
    n_checks++;
    if (hash_count !== exp_hc) begin n_fails++; $display("FAIL %s_hash_count: got %0d, required %0d", name, hash_count, exp_hc); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({rd_en, wr_en, dout, wr_addr, busy, done, error, hash_count} !==
        {1'b0, 1'b0, 8'h00, ADDR_W'(0), 1'b0, 1'b0, 1'b0, HCNT_W'(1)}) begin
      n_fails++;
      $display("FAIL reset_outputs: got rd%0b wr%0b d%02h a%0d b%0b dn%0b e%0b hc%0d, required zeros and hc 1",
               rd_en, wr_en, dout, wr_addr, busy, done, error, hash_count);
    end
    rst_n = 1'b1;
    exp_hc = HCNT_W'(1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_good();
    bit to;
    push_pkt(2, 8, 8'h01, 8'hCC, 1'b0, 1'b1);
    exp_hc = HCNT_W'(2);
    run_pkt(to);
    check_end("good", to, 1'b0, 1);
  endtask

  task automatic test_count_zero();
    bit to;
    push_pkt(0, 0, 8'h01, 8'hCC, 1'b0, 1'b0);
    run_pkt(to);
    check_end("count_zero", to, 1'b1, 0);
  endtask

  task automatic test_count_over();
    bit to;
    push_pkt(`NUM_HASHES + 1, 0, 8'h01, 8'hCC, 1'b0, 1'b0);
    run_pkt(to);
    check_end("count_over", to, 1'b1, 0);
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL count_over_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_bad_magic();
    bit to;
    push_pkt(1, 4, 8'h01, 8'h55, 1'b0, 1'b1);
    run_pkt(to);
    check_end("bad_magic", to, 1'b1, 0);
  endtask

  task automatic test_stall();
    bit to;
    n_checks++;
    if (error !== 1'b1) begin n_fails++; $display("FAIL error_sticky: got %0b, required 1", error); end
    toggle_en = 1'b1;
    push_pkt(1, 4, 8'h0A, 8'hCC, 1'b0, 1'b1);
    exp_hc = HCNT_W'(1);
    run_pkt(to);
    toggle_en = 1'b0;
    check_end("stall", to, 1'b0, 1);
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    push_pkt(2, 8, 8'h01, 8'hCC, 1'b0, 1'b1);
    wr_seen = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    n = 0;
    while (wr_seen < 3 && n < 200) begin @(negedge CLK); n++; end
    n_checks++;
    if (n >= 200) begin n_fails++; $display("FAIL reset_mid_wait: got %0d writes, required 3", wr_seen); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, wr_en, dout, wr_addr, busy, done, error, hash_count} !==
        {1'b0, 1'b0, 8'h00, ADDR_W'(0), 1'b0, 1'b0, 1'b0, HCNT_W'(1)}) begin
      n_fails++;
      $display("FAIL reset_mid_outputs: got rd%0b wr%0b d%02h a%0d b%0b dn%0b e%0b hc%0d, required zeros and hc 1",
               rd_en, wr_en, dout, wr_addr, busy, done, error, hash_count);
    end
    repeat (2) @(negedge CLK);
    fifo.delete();
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge CLK);
    push_pkt(3, 12, 8'h07, 8'hCC, 1'b0, 1'b1);
    exp_hc = HCNT_W'(3);
    run_pkt(to);
    check_end("after_reset", to, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    bit to;
    push_pkt(1, 4, 8'h21, 8'hCC, 1'b0, 1'b1);
    push_pkt(`NUM_HASHES, 4 * `NUM_HASHES, 8'h03, 8'hCC, 1'b0, 1'b1);
    exp_hc = HCNT_W'(1);
    run_pkt(to);
    n_checks++;
    if (hash_count !== exp_hc) begin n_fails++; $display("FAIL b2b_first_hc: got %0d, required %0d", hash_count, exp_hc); end
    exp_hc = HCNT_W'(`NUM_HASHES);
    run_pkt(to);
    check_end("b2b_max", to, 1'b0, 1);
  endtask

`ifdef CMP_CONFIG_CHECKSUM_EN
  task automatic test_checksum();
    bit to;
    push_pkt(1, 4, 8'h11, 8'hCC, 1'b0, 1'b1);
    exp_hc = HCNT_W'(1);
    run_pkt(to);
    check_end("csum_good", to, 1'b0, 1);
    push_pkt(1, 4, 8'h11, 8'hCC, 1'b1, 1'b1);
    run_pkt(to);
    check_end("csum_bad", to, 1'b1, 0);
  endtask
`endif

  initial begin
    din = 8'h00; empty = 1'b1; start = 1'b0; rst_n = 1'b0;
    test_reset();
    test_good();
    test_count_zero();
    test_count_over();
    test_bad_magic();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef CMP_CONFIG_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
